// File: rtl/mult_accumulator.sv
// Signed dot-product accumulator behind generic_mult: sums acc_len products and hands the sum off over valid/ready.
// Optional MULT_ACC_SAT_EN: saturating adds with a sticky acc_ovf; otherwise adds wrap and acc_ovf is 0.
module mult_accumulator #(
  parameter int MAX_PRECISION = 32,
  parameter int ACC_GUARD     = 8,
  parameter int LEN_W         = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   en,
  input  logic [5:0]                             precision,
  input  logic [LEN_W-1:0]                       acc_len,
  input  logic [2*MAX_PRECISION-1:0]             prod_in,
  input  logic                                   prod_valid,
  output logic                                   prod_ready,
  output logic [2*MAX_PRECISION+ACC_GUARD-1:0]   acc_out,
  output logic                                   acc_valid,
  input  logic                                   acc_ready,
  output logic                                   acc_ovf,
  output logic                                   busy
);

  localparam int PW = 2 * MAX_PRECISION;
  localparam int AW = PW + ACC_GUARD;

  // state | meaning
  // IDLE  | no sum in progress, waiting for the first term
  // ACCUM | partial sum held, more terms expected
  // HOLD  | finished sum presented on acc_out until accepted
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;

  logic                term_hs;
  logic                out_hs;
  logic                start;
  logic [LEN_W-1:0]    start_len;
  logic [AW-1:0]       ext_p;
  logic [AW-1:0]       sum_raw;
  logic [AW-1:0]       add_res;
  logic                add_ovf;

  // Keep the low 2*precision bits of the product and sign-extend them to AW.
  function automatic logic [AW-1:0] ext(input logic [PW-1:0] p, input logic [5:0] prec);
    int ew;
    int sh;
    logic signed [AW-1:0] t;
    case (prec)
      6'd4:    ew = 8;
      6'd8:    ew = 16;
      6'd16:   ew = 32;
      6'd32:   ew = 64;
      default: ew = PW;
    endcase
    if (ew > PW) ew = PW;
    sh = AW - ew;
    t  = AW'($signed(p));
    t  = t <<< sh;
    t  = t >>> sh;
    return t;
  endfunction

  always_comb begin
    prod_ready = 1'b0;
    if (rst_n) begin
      case (state_q)
        HOLD:    prod_ready = en & acc_ready;
        default: prod_ready = en;
      endcase
    end
  end

  assign acc_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign acc_out   = acc_q;

  assign term_hs   = prod_valid & prod_ready & en;
  assign out_hs    = acc_valid & acc_ready & en;
  assign start     = term_hs & ((state_q == IDLE) | (state_q == HOLD));
  assign start_len = (acc_len == '0) ? LEN_W'(1) : acc_len;
  assign ext_p     = ext(prod_in, precision);
  assign sum_raw   = acc_q + ext_p;

`ifdef MULT_ACC_SAT_EN
  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  logic ovf_q, ovf_d;

  // Same-sign operands producing an opposite-sign result is the only overflow case.
  always_comb begin
    add_ovf = (acc_q[AW-1] == ext_p[AW-1]) && (sum_raw[AW-1] != acc_q[AW-1]);
    add_res = sum_raw;
    if (add_ovf) add_res = acc_q[AW-1] ? ACC_MIN : ACC_MAX;
  end

  always_comb begin
    ovf_d = ovf_q;
    if (start)
      ovf_d = 1'b0;
    else if (term_hs && state_q == ACCUM)
      ovf_d = ovf_q | add_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign acc_ovf = ovf_q;
`else
  assign add_ovf = 1'b0;
  assign add_res = sum_raw;
  assign acc_ovf = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = start_len;
          acc_d   = ext_p;
          cnt_d   = LEN_W'(1);
          state_d = (start_len == LEN_W'(1)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (term_hs) begin
          acc_d = add_res;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) state_d = HOLD;
        end
      end
      HOLD: begin
        // A term can only be accepted here alongside the output handshake, so no bubble.
        if (start) begin
          len_d   = start_len;
          acc_d   = ext_p;
          cnt_d   = LEN_W'(1);
          state_d = (start_len == LEN_W'(1)) ? HOLD : ACCUM;
        end else if (out_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_mult_accumulator.sv
// Scoreboard bench for mult_accumulator: directed sums pushed as expectations, monitors pop on output handshakes.
module tb_mult_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [5:0]  precision;
  logic [7:0]  acc_len;
  logic [63:0] prod_in;
  logic        prod_valid;
  logic        prod_ready;
  logic [71:0] acc_out;
  logic        acc_valid;
  logic        acc_ready;
  logic        acc_ovf;
  logic        busy;

  logic [7:0]  s_prod_in;
  logic        s_prod_valid;
  logic        s_prod_ready;
  logic [7:0]  s_acc_out;
  logic        s_acc_valid;
  logic        s_acc_ovf;
  logic        s_busy;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [71:0] acc; logic ovf; } exp_t;
  exp_t q[$];
  exp_t sq[$];

  always #5 clk = ~clk;

  mult_accumulator dut (
    .clk(clk), .rst_n(rst_n), .en(en), .precision(precision), .acc_len(acc_len),
    .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_ovf(acc_ovf), .busy(busy)
  );

  mult_accumulator #(.MAX_PRECISION(4), .ACC_GUARD(0), .LEN_W(8)) u_small (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .precision(6'd4), .acc_len(8'd2),
    .prod_in(s_prod_in), .prod_valid(s_prod_valid), .prod_ready(s_prod_ready),
    .acc_out(s_acc_out), .acc_valid(s_acc_valid), .acc_ready(1'b1),
    .acc_ovf(s_acc_ovf), .busy(s_busy)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n && en && acc_valid && acc_ready) begin
      if (q.size() == 0) chk("unexpected_output", 72'd1, 72'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("acc_out", acc_out, e.acc);
        chk("acc_ovf", {71'd0, acc_ovf}, {71'd0, e.ovf});
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && s_acc_valid) begin
      if (sq.size() == 0) chk("small_unexpected_output", 72'd1, 72'd0);
      else begin
        exp_t e;
        e = sq.pop_front();
        chk("small_acc_out", {64'd0, s_acc_out}, e.acc);
        chk("small_acc_ovf", {71'd0, s_acc_ovf}, {71'd0, e.ovf});
      end
    end
  end

  function automatic exp_t mk(input logic [71:0] a);
    exp_t e;
    e.acc = a;
    e.ovf = 1'b0;
    return e;
  endfunction

  // Present one term and return just after the posedge where it was accepted.
  task automatic send(input logic [63:0] p);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    prod_in = p;
    prod_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = prod_ready & en;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) chk("send_timeout", 72'd1, 72'd0);
    prod_valid = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    exp_t se;
    rst_n = 1'b0; en = 1'b1; precision = 6'd8; acc_len = 8'd3;
    prod_in = '0; prod_valid = 1'b0; acc_ready = 1'b1;
    s_prod_in = '0; s_prod_valid = 1'b0;
    #12;
    chk("rst_acc_valid", {71'd0, acc_valid}, 72'd0);
    chk("rst_acc_out", acc_out, 72'd0);
    chk("rst_busy", {71'd0, busy}, 72'd0);
    chk("rst_prod_ready", {71'd0, prod_ready}, 72'd0);
    chk("rst_acc_ovf", {71'd0, acc_ovf}, 72'd0);
    @(negedge clk); rst_n = 1'b1;
    cycle();

    // Reset mid-ACCUM discards the partial sum at once
    acc_len = 8'd4;
    send(64'd5); send(64'd6);
    chk("accum_busy", {71'd0, busy}, 72'd1);
    #2 rst_n = 1'b0; #1;
    chk("midrst_acc_valid", {71'd0, acc_valid}, 72'd0);
    chk("midrst_busy", {71'd0, busy}, 72'd0);
    chk("midrst_acc_out", acc_out, 72'd0);
    @(negedge clk); rst_n = 1'b1;
    cycle();
    acc_len = 8'd2;
    q.push_back(mk(72'd12));
    send(64'd5); send(64'd7);
    cycle();

    // precision 8, three terms back-to-back: 248 - 16 - 248 = -16
    precision = 6'd8; acc_len = 8'd3;
    q.push_back(mk(-72'sd16));
    send(64'd248); send(-64'sd16); send(-64'sd248);
    chk("lat_valid", {71'd0, acc_valid}, 72'd1);
    cycle();
    chk("valid_one_cycle", {71'd0, acc_valid}, 72'd0);

    // precision 4 keeps only the low byte: 0xF0 -> -16
    precision = 6'd4; acc_len = 8'd1;
    q.push_back(mk(-72'sd16));
    send(64'h00F0);
    cycle();

    // acc_len=0 behaves as 1
    precision = 6'd8; acc_len = 8'd0;
    q.push_back(mk(72'd9));
    send(64'd9);
    cycle();

    // acc_len change mid-sum is ignored
    acc_len = 8'd3;
    q.push_back(mk(72'd6));
    send(64'd1);
    acc_len = 8'd1;
    send(64'd2); send(64'd3);
    cycle();

    // precision change applies to the next term: 0xFFFF@8 = -1, then 0x1FFFF@16 = 131071
    precision = 6'd8; acc_len = 8'd2;
    q.push_back(mk(72'd131070));
    send(64'h1FFFF);
    precision = 6'd16;
    send(64'h1FFFF);
    cycle();

    // Backpressure in HOLD with a pending term
    precision = 6'd8; acc_len = 8'd2; acc_ready = 1'b0;
    q.push_back(mk(72'd30));
    q.push_back(mk(72'd70));
    send(64'd10); send(64'd20);
    prod_in = 64'd30; prod_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {71'd0, acc_valid}, 72'd1);
      chk("hold_stable", acc_out, 72'd30);
      chk("hold_prod_ready", {71'd0, prod_ready}, 72'd0);
      cycle();
    end
    acc_ready = 1'b1;
    @(negedge clk);
    chk("release_prod_ready", {71'd0, prod_ready}, 72'd1);
    cycle();
    chk("no_bubble_busy", {71'd0, busy}, 72'd1);
    chk("no_bubble_valid", {71'd0, acc_valid}, 72'd0);
    send(64'd40);
    cycle();

    // en=0 freezes a sum two terms in
    acc_len = 8'd4;
    q.push_back(mk(72'd10));
    send(64'd1); send(64'd2);
    en = 1'b0; prod_in = 64'd100; prod_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("en0_prod_ready", {71'd0, prod_ready}, 72'd0);
      chk("en0_acc", acc_out, 72'd3);
      cycle();
    end
    en = 1'b1;
    send(64'd3); send(64'd4);
    cycle();

    // Narrow instance: 64 + 64 in an 8-bit accumulator
`ifdef MULT_ACC_SAT_EN
    se.acc = 72'd127; se.ovf = 1'b1;
`else
    se.acc = 72'h80; se.ovf = 1'b0;
`endif
    sq.push_back(se);
    s_prod_in = 8'd64; s_prod_valid = 1'b1;
    n = 0;
    for (int k = 0; k < 2; k++) begin
      bit ok;
      ok = 0;
      while (!ok && n < 100) begin
        @(negedge clk);
        ok = s_prod_ready;
        cycle();
        n++;
      end
    end
    s_prod_valid = 1'b0;
    if (n >= 100) chk("small_timeout", 72'd1, 72'd0);

    n = 0;
    while ((q.size() != 0 || sq.size() != 0) && n < 50) begin
      cycle();
      n++;
    end
    chk("main_queue_drained", 72'(q.size()), 72'd0);
    chk("small_queue_drained", 72'(sq.size()), 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
